// File: rtl/intr_pkg.sv
// ---------------------------------------------------------------------------
// intr_pkg : shared sizes and FSM encodings for the interrupt controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package intr_pkg;

  localparam int N_SRC_DEF = 18;
  localparam int VEC_W_DEF = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

endpackage

`default_nettype wire

// File: rtl/intr_if.sv
// ---------------------------------------------------------------------------
// intr_if : request pins, CPU handshake and debug view of the controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

import intr_pkg::*;

interface intr_if;

  logic [N_SRC_DEF-1:0] in_intp;
  logic                 glob_ie;
  logic                 en_i;
  logic                 en_o;
  logic                 mask_we;
  logic [N_SRC_DEF-1:0] mask_wdata;
  logic                 ack;
  logic                 eoi;
  logic                 irq;
  logic [VEC_W_DEF-1:0] vec;
  logic                 busy;
  logic [N_SRC_DEF-1:0] pending;

  modport master (
    output in_intp, glob_ie, en_i, en_o, mask_we, mask_wdata, ack, eoi,
    input  irq, vec, busy, pending
  );

  modport slave (
    input  in_intp, glob_ie, en_i, en_o, mask_we, mask_wdata, ack, eoi,
    output irq, vec, busy, pending
  );

endinterface

`default_nettype wire

// File: rtl/intr_prio_enc.sv
// ---------------------------------------------------------------------------
// intr_prio_enc : lowest-index-first priority encoder (combinational)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

import intr_pkg::*;

module intr_prio_enc #(
  parameter int N_SRC = N_SRC_DEF,
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic [N_SRC-1:0] req,
  output logic [VEC_W-1:0] idx,
  output logic             any_valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = VEC_W'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl : edge capture, mask gating and irq/ack/eoi handshake FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

import intr_pkg::*;

module intr_ctrl (
  input logic   clk,
  input logic   rst,
  intr_if.slave bus
);

  logic [N_SRC_DEF-1:0] in_prev;
  logic [N_SRC_DEF-1:0] pending_reg;
  logic [N_SRC_DEF-1:0] pending_nxt;
  logic [N_SRC_DEF-1:0] mask_reg;
  logic [N_SRC_DEF-1:0] edge_det;
  logic [N_SRC_DEF-1:0] elig;
  logic [1:0]           state;
  logic                 irq_reg;
  logic                 busy_reg;
  logic [VEC_W_DEF-1:0] vec_reg;
  logic [VEC_W_DEF-1:0] sel_idx;
  logic                 sel_valid;
  logic                 take_ack;

  assign edge_det = bus.in_intp & ~in_prev;
  assign elig     = pending_reg & mask_reg;
  assign take_ack = (state == ST_REQ) && bus.ack;

  intr_prio_enc #(
    .N_SRC (N_SRC_DEF),
    .VEC_W (VEC_W_DEF)
  ) u_prio (
    .req       (elig),
    .idx       (sel_idx),
    .any_valid (sel_valid)
  );

  // Set is applied after the clear so a fresh edge on the serviced bit survives.
  always_comb begin
    pending_nxt = pending_reg;
    if (take_ack) begin
      pending_nxt[vec_reg] = 1'b0;
    end
    if (bus.en_i) begin
      pending_nxt = pending_nxt | edge_det;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_prev     <= '0;
      pending_reg <= '0;
      mask_reg    <= '1;
    end else begin
      in_prev     <= bus.in_intp;
      pending_reg <= pending_nxt;
      if (bus.mask_we) begin
        mask_reg <= bus.mask_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      irq_reg  <= 1'b0;
      busy_reg <= 1'b0;
      vec_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid && bus.glob_ie && bus.en_o) begin
            state   <= ST_REQ;
            irq_reg <= 1'b1;
            vec_reg <= sel_idx;
          end
        end
        ST_REQ: begin
          if (bus.ack) begin
            state    <= ST_SERV;
            irq_reg  <= 1'b0;
            busy_reg <= 1'b1;
          end else if (!bus.glob_ie || !bus.en_o || !mask_reg[vec_reg]) begin
            state   <= ST_IDLE;
            irq_reg <= 1'b0;
          end
        end
        ST_SERV: begin
          if (bus.eoi) begin
            state    <= ST_IDLE;
            busy_reg <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          irq_reg  <= 1'b0;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq     = irq_reg;
  assign bus.vec     = vec_reg;
  assign bus.busy    = busy_reg;
  assign bus.pending = pending_reg;

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl : directed checks of intr_ctrl with hand-computed expectations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_intr_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  intr_if bus ();

  intr_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.in_intp    = '0;
    bus.glob_ie    = 1'b0;
    bus.en_i       = 1'b0;
    bus.en_o       = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.ack        = 1'b0;
    bus.eoi        = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_irq",     32'(bus.irq),     32'h0);
    chk("rst_busy",    32'(bus.busy),    32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_vec",     32'(bus.vec),     32'h0);

    // Priority between bits 0 and 2
    bus.glob_ie = 1'b1;
    bus.en_i    = 1'b1;
    bus.en_o    = 1'b1;
    bus.ack     = 1'b1;           // ack while idle must be ignored
    tick();
    bus.ack     = 1'b0;
    chk("idle_ack_busy", 32'(bus.busy), 32'h0);
    bus.in_intp = 18'd5;
    tick();
    chk("prio_pending", 32'(bus.pending), 32'h5);
    chk("prio_irq_t1",  32'(bus.irq),     32'h0);
    tick();
    chk("prio_irq_t2",  32'(bus.irq),     32'h1);
    chk("prio_vec0",    32'(bus.vec),     32'h0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("prio_serv_busy", 32'(bus.busy),    32'h1);
    chk("prio_serv_irq",  32'(bus.irq),     32'h0);
    chk("prio_clr0",      32'(bus.pending), 32'h4);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    chk("prio_eoi_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("prio_irq2", 32'(bus.irq), 32'h1);
    chk("prio_vec2", 32'(bus.vec), 32'h2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("prio_clr_all", 32'(bus.pending), 32'h0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi     = 1'b0;
    bus.in_intp = '0;
    tick();

    // Output gating with en_o low
    bus.en_o    = 1'b0;
    bus.in_intp = 18'h1 << 9;
    tick();
    chk("gate_pending", 32'(bus.pending), 32'h200);
    tick();
    chk("gate_irq_low", 32'(bus.irq), 32'h0);
    bus.en_o = 1'b1;
    tick();
    tick();
    chk("gate_irq", 32'(bus.irq), 32'h1);
    chk("gate_vec", 32'(bus.vec), 32'h9);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi     = 1'b0;
    bus.in_intp = '0;
    tick();

    // Mask write withdraws a presented request
    bus.in_intp = 18'h1 << 3;
    tick();
    tick();
    chk("mask_irq_up", 32'(bus.irq), 32'h1);
    chk("mask_vec3",   32'(bus.vec), 32'h3);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = ~(18'h1 << 3);
    tick();
    bus.mask_we = 1'b0;
    tick();
    chk("mask_irq_drop", 32'(bus.irq),        32'h0);
    chk("mask_busy",     32'(bus.busy),       32'h0);
    chk("mask_pend3",    32'(bus.pending[3]), 32'h1);
    tick();
    chk("mask_stay_idle", 32'(bus.irq), 32'h0);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = '1;
    tick();
    bus.mask_we = 1'b0;
    tick();
    chk("unmask_irq", 32'(bus.irq), 32'h1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    chk("unmask_clr", 32'(bus.pending), 32'h0);

    // New edge on the serviced source while in SERV
    bus.in_intp = 18'h1 << 4;
    tick();
    tick();
    chk("serv_vec4", 32'(bus.vec), 32'h4);
    bus.ack = 1'b1;
    tick();
    bus.ack     = 1'b0;
    bus.in_intp = '0;
    tick();
    bus.in_intp = 18'h1 << 4;
    tick();
    chk("serv_repend", 32'(bus.pending), 32'h10);
    chk("serv_busy",   32'(bus.busy),    32'h1);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    chk("serv_reirq", 32'(bus.irq), 32'h1);
    chk("serv_revec", 32'(bus.vec), 32'h4);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi     = 1'b0;
    bus.in_intp = '0;
    tick();

    // ack coinciding with glob_ie falling still wins
    bus.in_intp = 18'h1 << 7;
    tick();
    tick();
    bus.ack     = 1'b1;
    bus.glob_ie = 1'b0;
    tick();
    bus.ack     = 1'b0;
    bus.glob_ie = 1'b1;
    chk("ack_vs_ie_busy", 32'(bus.busy),    32'h1);
    chk("ack_vs_ie_clr",  32'(bus.pending), 32'h0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi     = 1'b0;
    bus.in_intp = '0;
    tick();

    // Reset while in service with bits 0 and 5 pending
    bus.in_intp = 18'h21;
    tick();
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack     = 1'b0;
    bus.in_intp = 18'h20;
    tick();
    bus.in_intp = 18'h21;
    tick();
    chk("rstmid_pending", 32'(bus.pending), 32'h21);
    chk("rstmid_busy",    32'(bus.busy),    32'h1);
    rst         = 1'b1;
    bus.in_intp = '0;
    tick();
    rst = 1'b0;
    chk("rstmid_busy0", 32'(bus.busy),    32'h0);
    chk("rstmid_irq0",  32'(bus.irq),     32'h0);
    chk("rstmid_pend0", 32'(bus.pending), 32'h0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    chk("rstmid_eoi_busy", 32'(bus.busy), 32'h0);
    chk("rstmid_eoi_irq",  32'(bus.irq),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
